mips_harvard_cpu: RTL and testbench
===================================

// Module: mips_harvard_cpu
// PURPOSE
//  Single-cycle MIPS32 subset CPU with separate instruction and data buses.
//  Fetches from a combinational instruction ROM and reads/writes a data RAM
//  with combinational read and single-cycle write.
//  Runs from the reset vector until it jumps to address 0, then drops active.
//  Exposes $v0 (register 2) for result checking.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  PC value loaded on reset
//  HALT_ADDR     32'h00000000  PC value that stops execution
// PORTS
//  clk             in   1   single clock; all state updates on rising edge
//  reset           in   1   asynchronous, active-low reset
//  active          out  1   1 while running; 0 once halted
//  register_v0     out  32  current contents of GPR $2 (combinational)
//  clk_enable      in   1   0 freezes all state (PC, GPRs, active, memory writes)
//  instr_address   out  32  PC (combinational from state)
//  instr_readdata  in   32  instruction word at instr_address, same cycle
//  data_address    out  32  byte address for load/store: rs + sign-extended imm
//  data_write      out  1   store strobe; RAM writes on next rising clk edge
//  data_read       out  1   load strobe; data_readdata valid same cycle
//  data_writedata  out  32  store data (bus byte order, see below)
//  data_readdata   in   32  load data (bus byte order)
// BEHAVIOUR
//  - Reset (reset=0, async): PC=RESET_VECTOR, all 32 GPRs=0, active=1,
//    delay-slot branch target cleared; data_write=data_read=0 during reset.
//  - One instruction per enabled clock; outputs are combinational decodes of
//    the current instruction. $0 always reads 0; writes to it are discarded.
//  - Byte order: memory is little-endian, byte-addressed. Both buses carry
//    {byte@A, byte@A+1, byte@A+2, byte@A+3} in bits [31:24]..[7:0]; the CPU
//    byte-reverses between bus and register on fetch, LW and SW. Register
//    value 0x12345678 stored by SW appears on the bus as 0x78563412.
//  - Supported: ADDU SUBU AND OR XOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR
//    JALR, ADDIU ANDI ORI XORI SLTI SLTIU LUI LW SW BEQ BNE J JAL.
//  - ADDIU/ADDU/SUBU: 32-bit modulo arithmetic, no overflow trap; ADDIU
//    sign-extends imm16; ANDI/ORI/XORI zero-extend; SLTI/SLTIU sign-extend
//    imm (SLTIU compares unsigned). LUI: rt = imm<<16.
//  - Branches/jumps have one delay slot: instruction at PC+4 always executes;
//    target = PC+4 + (sext(imm)<<2) for branches, {PC+4[31:28],idx,2'b00}
//    for J/JAL. JAL/JALR link PC+8 into $31 / rd.
//  - LW/SW require word-aligned addresses; misaligned behaviour undefined.
//    data_read=1 only for LW, data_write=1 only for SW, never both.
//  - Halt: when the PC advanced to is HALT_ADDR (after the delay slot
//    completes), active goes 0 on that edge; thereafter PC, GPRs frozen,
//    data_read=data_write=0. Only reset restarts.
//  - clk_enable=0: no state changes; data_write is forced 0.
//  - Unsupported opcodes execute as NOP.
//  - Reset asserted mid-program: immediate return to reset state; in-flight
//    store is not written.
// TESTING
//  1 Reset release, prog "ADDIU $2,$0,0x1111; JR $0; NOP" -> register_v0=0x00001111,
//    active=0 within 3 enabled cycles, no data_write pulses.
//  2 LUI $3,0x1234; ORI $3,$3,0x5678; SW $3,0($0); JR $0 -> after halt RAM
//    word 0 read via data bus = 0x78563412.
//  3 ADDIU $2,$0,-1; ADDIU $2,$2,1 -> v0 wraps to 0x00000000, no trap.
//  4 BEQ taken with ADDIU in delay slot -> delay-slot ADDIU executes, skipped
//    instruction after slot does not; verify via v0.
//  5 LW of bus word 0x44332211 into $2 -> v0=0x11223344.
//  6 Hold clk_enable=0 for 5 cycles mid-program -> PC, v0 unchanged,
//    data_write=0; pulse reset low mid-run -> PC=0xBFC00000, v0=0.

Source files
------------

// File: rtl/mips_harvard_cpu.sv
// mips_harvard_cpu: single-cycle MIPS32 subset core with separate instruction and data buses,
// running from RESET_VECTOR until control transfers to HALT_ADDR.
module mips_harvard_cpu #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   input  logic        clk_enable,
   output logic [31:0] instr_address,
   input  logic [31:0] instr_readdata,
   output logic [31:0] data_address,
   output logic        data_write,
   output logic        data_read,
   output logic [31:0] data_writedata,
   input  logic [31:0] data_readdata
);
   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   logic [31:0] pc_q, pc_d, npc_q, npc_d;
   logic        active_q, active_d;
   logic [31:0] gpr_q [32];
   logic [31:0] instr, rs_val, rt_val, imm_s, imm_z, pc4, pc8, jtgt, wr_data;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh, wr_addr;
   logic        wr_en, jump, run, gpr_we;

   assign instr  = bswap(instr_readdata);
   assign op     = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign sh     = instr[10:6];
   assign fn     = instr[5:0];
   assign rs_val = gpr_q[rs];
   assign rt_val = gpr_q[rt];
   assign imm_s  = {{16{instr[15]}}, instr[15:0]};
   assign imm_z  = {16'h0, instr[15:0]};
   assign pc4    = pc_q + 32'd4;
   assign pc8    = pc_q + 32'd8;
   assign run    = active_q & clk_enable;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = rt;
      wr_data = 32'h0;
      jump    = 1'b0;
      jtgt    = pc4 + {imm_s[29:0], 2'b00};
      case (op)
         6'h00: begin
            wr_addr = rd;
            wr_en   = 1'b1;
            jtgt    = rs_val;
            case (fn)
               6'h00: wr_data = rt_val << sh;
               6'h02: wr_data = rt_val >> sh;
               6'h03: wr_data = $signed(rt_val) >>> sh;
               6'h04: wr_data = rt_val << rs_val[4:0];
               6'h06: wr_data = rt_val >> rs_val[4:0];
               6'h07: wr_data = $signed(rt_val) >>> rs_val[4:0];
               6'h08: {wr_en, jump} = 2'b01;
               6'h09: {wr_data, jump} = {pc8, 1'b1};
               6'h21: wr_data = rs_val + rt_val;
               6'h23: wr_data = rs_val - rt_val;
               6'h24: wr_data = rs_val & rt_val;
               6'h25: wr_data = rs_val | rt_val;
               6'h26: wr_data = rs_val ^ rt_val;
               6'h2A: wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
               6'h2B: wr_data = {31'h0, rs_val < rt_val};
               default: wr_en = 1'b0;
            endcase
         end
         6'h02: {jump, jtgt} = {1'b1, pc4[31:28], instr[25:0], 2'b00};
         6'h03: begin
            {jump, jtgt} = {1'b1, pc4[31:28], instr[25:0], 2'b00};
            {wr_en, wr_addr, wr_data} = {1'b1, 5'd31, pc8};
         end
         6'h04: jump = rs_val == rt_val;
         6'h05: jump = rs_val != rt_val;
         6'h09: {wr_en, wr_data} = {1'b1, rs_val + imm_s};
         6'h0A: {wr_en, wr_data} = {1'b1, 31'h0, $signed(rs_val) < $signed(imm_s)};
         6'h0B: {wr_en, wr_data} = {1'b1, 31'h0, rs_val < imm_s};
         6'h0C: {wr_en, wr_data} = {1'b1, rs_val & imm_z};
         6'h0D: {wr_en, wr_data} = {1'b1, rs_val | imm_z};
         6'h0E: {wr_en, wr_data} = {1'b1, rs_val ^ imm_z};
         6'h0F: {wr_en, wr_data} = {1'b1, instr[15:0], 16'h0};
         6'h23: {wr_en, wr_data} = {1'b1, bswap(data_readdata)};
         default: ;
      endcase
   end

   // npc_q holds the delay-slot successor; a taken jump only redirects the one after it
   always_comb begin
      pc_d     = run ? npc_q : pc_q;
      npc_d    = run ? (jump ? jtgt : npc_q + 32'd4) : npc_q;
      active_d = active_q & ~(run & (npc_q == HALT_ADDR));
      gpr_we   = run & wr_en & (wr_addr != 5'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_VECTOR;
         npc_q    <= RESET_VECTOR + 32'd4;
         active_q <= 1'b1;
         for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
      end else begin
         pc_q     <= pc_d;
         npc_q    <= npc_d;
         active_q <= active_d;
         if (gpr_we) gpr_q[wr_addr] <= wr_data;
      end
   end

   assign active         = active_q;
   assign register_v0    = gpr_q[2];
   assign instr_address  = pc_q;
   assign data_address   = rs_val + imm_s;
   assign data_read      = reset & active_q & (op == 6'h23);
   assign data_write     = reset & run & (op == 6'h2B);
   assign data_writedata = bswap(rt_val);
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// tb_mips_harvard_cpu: directed and random programs checked cycle by cycle against an
// instruction-level model of the ISA (pending-branch style delay slot, byte-array memory).
module tb_mips_harvard_cpu;
   localparam logic [31:0] RV  = 32'hBFC00000;
   localparam logic [31:0] NOP = 32'h00000000;
   localparam logic [31:0] JR0 = 32'h00000008;

   logic        clk = 1'b0, reset = 1'b0, clk_enable = 1'b1;
   logic        active, data_write, data_read;
   logic [31:0] register_v0, instr_address, instr_readdata;
   logic [31:0] data_address, data_writedata, data_readdata;
   logic [7:0]  rom [1024];
   logic [7:0]  ram [256];
   logic [7:0]  mram [256];
   logic [31:0] prog [256];
   logic [31:0] mregs [32];
   logic [31:0] mpc, mtgt;
   logic        mbr, mactive;
   logic [9:0]  ia;
   logic [7:0]  da;
   int          plen, n_tests = 0, n_fail = 0, n_wr = 0, cyc;

   mips_harvard_cpu dut (
      .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
      .clk_enable(clk_enable), .instr_address(instr_address), .instr_readdata(instr_readdata),
      .data_address(data_address), .data_write(data_write), .data_read(data_read),
      .data_writedata(data_writedata), .data_readdata(data_readdata)
   );

   always #5 clk = ~clk;

   assign ia = instr_address[9:0];
   assign da = {data_address[7:2], 2'b00};
   assign instr_readdata = (instr_address[31:10] == RV[31:10]) ?
      {rom[ia], rom[ia + 10'd1], rom[ia + 10'd2], rom[ia + 10'd3]} : 32'h0;
   assign data_readdata = {ram[da], ram[da + 8'd1], ram[da + 8'd2], ram[da + 8'd3]};

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] s, t, d, h, input logic [5:0] f);
      return {6'h00, s, t, d, h, f};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
      return {o, s, t, im};
   endfunction

   function automatic logic [31:0] mfetch(input logic [31:0] a);
      logic [31:0] off;
      off = a - RV;
      return (off < 32'd1024) ? prog[off[9:2]] : 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural ISA model ----------------
   task automatic mreset();
      mpc = RV; mbr = 1'b0; mtgt = 32'h0; mactive = 1'b1;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
   endtask

   task automatic wreg(input logic [4:0] d, input logic [31:0] v);
      if (d != 5'd0) mregs[d] = v;
   endtask

   task automatic take(input logic [31:0] t);
      mbr = 1'b1; mtgt = t;
   endtask

   task automatic mstep();
      logic [31:0] w, a, b, si, zi, ea, p4, nxt;
      logic [7:0]  e;
      w = mfetch(mpc);
      a = mregs[w[25:21]]; b = mregs[w[20:16]];
      si = {{16{w[15]}}, w[15:0]}; zi = {16'h0, w[15:0]};
      ea = a + si; e = ea[7:0]; p4 = mpc + 32'd4;
      nxt = mbr ? mtgt : p4;
      mbr = 1'b0;
      case (w[31:26])
         6'h00: case (w[5:0])
            6'h00: wreg(w[15:11], b << w[10:6]);
            6'h02: wreg(w[15:11], b >> w[10:6]);
            6'h03: wreg(w[15:11], $signed(b) >>> w[10:6]);
            6'h04: wreg(w[15:11], b << a[4:0]);
            6'h06: wreg(w[15:11], b >> a[4:0]);
            6'h07: wreg(w[15:11], $signed(b) >>> a[4:0]);
            6'h08: take(a);
            6'h09: begin take(a); wreg(w[15:11], mpc + 32'd8); end
            6'h21: wreg(w[15:11], a + b);
            6'h23: wreg(w[15:11], a - b);
            6'h24: wreg(w[15:11], a & b);
            6'h25: wreg(w[15:11], a | b);
            6'h26: wreg(w[15:11], a ^ b);
            6'h2A: wreg(w[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            6'h2B: wreg(w[15:11], (a < b) ? 32'd1 : 32'd0);
            default: ;
         endcase
         6'h02: take({p4[31:28], w[25:0], 2'b00});
         6'h03: begin take({p4[31:28], w[25:0], 2'b00}); wreg(5'd31, mpc + 32'd8); end
         6'h04: if (a == b) take(p4 + (si << 2));
         6'h05: if (a != b) take(p4 + (si << 2));
         6'h09: wreg(w[20:16], ea);
         6'h0A: wreg(w[20:16], ($signed(a) < $signed(si)) ? 32'd1 : 32'd0);
         6'h0B: wreg(w[20:16], (a < si) ? 32'd1 : 32'd0);
         6'h0C: wreg(w[20:16], a & zi);
         6'h0D: wreg(w[20:16], a | zi);
         6'h0E: wreg(w[20:16], a ^ zi);
         6'h0F: wreg(w[20:16], {w[15:0], 16'h0});
         6'h23: wreg(w[20:16], {mram[e + 8'd3], mram[e + 8'd2], mram[e + 8'd1], mram[e]});
         6'h2B: begin
            mram[e] = b[7:0]; mram[e + 8'd1] = b[15:8];
            mram[e + 8'd2] = b[23:16]; mram[e + 8'd3] = b[31:24];
         end
         default: ;
      endcase
      mpc = nxt;
      if (mpc == 32'h0) mactive = 1'b0;
   endtask

   initial begin
      mreset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) mreset();
         else if (clk_enable && mactive) mstep();
      end
   end

   // data RAM: strobes sampled mid-cycle, committed at the following edge
   initial begin
      logic        wp;
      logic [7:0]  wa;
      logic [31:0] wv;
      forever begin
         @(negedge clk);
         wp = data_write; wa = da; wv = data_writedata;
         @(posedge clk);
         if (wp && reset) begin
            ram[wa] = wv[31:24]; ram[wa + 8'd1] = wv[23:16];
            ram[wa + 8'd2] = wv[15:8]; ram[wa + 8'd3] = wv[7:0];
         end
      end
   end

   // per-cycle comparison against the model
   initial begin
      logic [31:0] w;
      logic        er, ew;
      forever begin
         @(negedge clk);
         if (data_write) n_wr++;
         if (!reset) begin
            check("rst_pc", instr_address, RV);
            check("rst_strobes", {30'h0, data_read, data_write}, 32'h0);
         end else begin
            w  = mfetch(mpc);
            er = mactive && w[31:26] == 6'h23;
            ew = mactive && clk_enable && w[31:26] == 6'h2B;
            check("pc", instr_address, mpc);
            check("active", {31'h0, active}, {31'h0, mactive});
            check("v0", register_v0, mregs[2]);
            check("data_read", {31'h0, data_read}, {31'h0, er});
            check("data_write", {31'h0, data_write}, {31'h0, ew});
            if (er || ew) check("data_address", data_address, mregs[w[25:21]] + {{16{w[15]}}, w[15:0]});
            if (ew) check("data_writedata", data_writedata, bswap(mregs[w[20:16]]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_prog();
      @(posedge clk); #2;
      reset = 1'b0; clk_enable = 1'b1; plen = 0; n_wr = 0;
      for (int i = 0; i < 256; i++) prog[i] = NOP;
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
   endtask

   task automatic fill_ram(input bit rnd);
      for (int i = 0; i < 256; i++) begin
         ram[i] = rnd ? 8'($urandom) : 8'h00;
         mram[i] = ram[i];
      end
   endtask

   task automatic emit(input logic [31:0] w);
      prog[plen] = w;
      rom[10'(4 * plen)] = w[7:0];     rom[10'(4 * plen + 1)] = w[15:8];
      rom[10'(4 * plen + 2)] = w[23:16]; rom[10'(4 * plen + 3)] = w[31:24];
      plen++;
   endtask

   task automatic go();
      @(posedge clk); #2;
      check("rst_v0", register_v0, 32'h0);
      check("rst_active", {31'h0, active}, 32'h1);
      reset = 1'b1;
   endtask

   task automatic run_halt(input int budget, output int c);
      c = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk); @(negedge clk);
         if (!active) begin c = i; break; end
      end
      check("halted", {31'h0, active}, 32'h0);
   endtask

   task automatic gen_prog(input int n);
      logic [31:0] w;
      logic [4:0]  s, t, d;
      logic [15:0] im;
      int          k, sel;
      bit          last_br;
      last_br = 1'b0;
      for (int i = 0; i < n; i++) begin
         s = 5'($urandom_range(0, 4)); t = 5'($urandom_range(0, 4)); d = 5'($urandom_range(0, 4));
         im = 16'($urandom); sel = $urandom_range(0, 2);
         k = $urandom_range(0, 15);
         if (k == 13 && (last_br || i > n - 3)) k = 15;
         case (k)
            0: w = enc_r(s, t, d, 5'd0, 6'h21);
            1: w = enc_r(s, t, d, 5'd0, 6'h23);
            2: w = enc_r(s, t, d, 5'd0, 6'h24);
            3: w = enc_r(s, t, d, 5'd0, 6'h25);
            4: w = enc_r(s, t, d, 5'd0, 6'h26);
            5: w = enc_r(s, t, d, 5'd0, 6'h2A);
            6: w = enc_r(s, t, d, 5'd0, 6'h2B);
            7: w = enc_r(5'd0, t, d, 5'($urandom), (sel == 0) ? 6'h00 : (sel == 1) ? 6'h02 : 6'h03);
            8: w = enc_r(s, t, d, 5'd0, (sel == 0) ? 6'h04 : (sel == 1) ? 6'h06 : 6'h07);
            9: w = enc_i(6'(9 + $urandom_range(0, 5)), s, t, im);
            10: w = enc_i(6'h0F, 5'd0, t, im);
            11: w = enc_i(6'h23, 5'd0, t, {8'h00, 6'($urandom), 2'b00});
            12: w = enc_i(6'h2B, 5'd0, t, {8'h00, 6'($urandom), 2'b00});
            13: w = enc_i((sel == 0) ? 6'h04 : 6'h05, s, t, 16'($urandom_range(0, 2)));
            14: w = (sel == 0) ? {6'h3F, 26'($urandom)} : enc_r(s, t, 5'd2, 5'd0, 6'h3F);
            default: w = enc_i(6'h09, s, 5'd2, im);
         endcase
         last_br = (k == 13);
         emit(w);
      end
      emit(JR0); emit(NOP);
   endtask

   // ---------------- tests ----------------
   initial begin
      logic [31:0] jt;
      // 1: immediate to v0 then jump to halt address
      start_prog(); fill_ram(1'b0);
      emit(enc_i(6'h09, 5'd0, 5'd2, 16'h1111)); emit(JR0); emit(NOP);
      go(); run_halt(10, cyc);
      check("t1_v0", register_v0, 32'h00001111);
      check("t1_cycles", 32'(cyc), 32'd3);
      check("t1_no_writes", 32'(n_wr), 32'd0);
      check("t1_pc_halted", instr_address, 32'h0);

      // 2: store byte order on the bus
      start_prog(); fill_ram(1'b0);
      emit(enc_i(6'h0F, 5'd0, 5'd3, 16'h1234)); emit(enc_i(6'h0D, 5'd3, 5'd3, 16'h5678));
      emit(enc_i(6'h2B, 5'd0, 5'd3, 16'h0000)); emit(JR0); emit(NOP);
      go(); run_halt(10, cyc);
      check("t2_ram0", {ram[0], ram[1], ram[2], ram[3]}, 32'h78563412);

      // 3: modulo wrap
      start_prog(); fill_ram(1'b0);
      emit(enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF)); emit(enc_i(6'h09, 5'd2, 5'd2, 16'h0001));
      emit(JR0); emit(NOP);
      go(); run_halt(10, cyc);
      check("t3_wrap", register_v0, 32'h00000000);

      // 4: taken branch runs its delay slot, skips the next one
      start_prog(); fill_ram(1'b0);
      emit(enc_i(6'h09, 5'd0, 5'd2, 16'd1)); emit(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
      emit(enc_i(6'h09, 5'd2, 5'd2, 16'd2)); emit(enc_i(6'h09, 5'd2, 5'd2, 16'd4));
      emit(enc_i(6'h09, 5'd2, 5'd2, 16'd8)); emit(JR0); emit(NOP);
      go(); run_halt(12, cyc);
      check("t4_beq", register_v0, 32'd11);

      // 5: load byte order
      start_prog(); fill_ram(1'b0);
      ram[16] = 8'h44; ram[17] = 8'h33; ram[18] = 8'h22; ram[19] = 8'h11;
      for (int i = 16; i < 20; i++) mram[i] = ram[i];
      emit(enc_i(6'h23, 5'd0, 5'd2, 16'h0010)); emit(JR0); emit(NOP);
      go(); run_halt(10, cyc);
      check("t5_lw", register_v0, 32'h11223344);

      // 7: JAL link and jump target
      start_prog(); fill_ram(1'b0);
      jt = RV + 32'd16;
      emit({6'h03, jt[27:2]}); emit(enc_i(6'h09, 5'd0, 5'd3, 16'd7));
      emit(enc_i(6'h09, 5'd0, 5'd2, 16'd99)); emit(NOP);
      emit(enc_r(5'd31, 5'd3, 5'd2, 5'd0, 6'h21)); emit(JR0); emit(NOP);
      go(); run_halt(12, cyc);
      check("t7_jal", register_v0, 32'hBFC0000F);

      // 6: clock-enable freeze, then reset over a pending store
      start_prog(); fill_ram(1'b0);
      emit(enc_i(6'h09, 5'd0, 5'd2, 16'd5)); emit(enc_i(6'h09, 5'd2, 5'd2, 16'd1));
      emit(enc_i(6'h2B, 5'd0, 5'd2, 16'h0020)); emit(enc_i(6'h09, 5'd2, 5'd2, 16'd1));
      emit(JR0); emit(NOP);
      go();
      repeat (2) begin @(posedge clk); #2; end
      check("t6_pc_run", instr_address, RV + 32'd8);
      check("t6_v0_run", register_v0, 32'd6);
      check("t6_sw_strobe", {31'h0, data_write}, 32'h1);
      clk_enable = 1'b0;
      repeat (5) begin @(posedge clk); #2; end
      check("t6_pc_hold", instr_address, RV + 32'd8);
      check("t6_v0_hold", register_v0, 32'd6);
      check("t6_write_hold", {31'h0, data_write}, 32'h0);
      clk_enable = 1'b1; reset = 1'b0; #1;
      check("t6_pc_reset", instr_address, RV);
      check("t6_v0_reset", register_v0, 32'h0);
      @(posedge clk); #2;
      check("t6_store_dropped", {ram[32], ram[33], ram[34], ram[35]}, 32'h0);

      // random programs with random clock-enable gaps
      for (int p = 0; p < 20; p++) begin
         start_prog(); fill_ram(1'b1);
         gen_prog(int'($urandom_range(8, 40)));
         go();
         for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            clk_enable = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            if (!active) break;
         end
         check("rnd_halted", {31'h0, active}, 32'h0);
         clk_enable = 1'b1;
      end

      @(posedge clk); #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
